// File: rtl/nrs_demap_ctrl.sv
// ---------------------------------------------------------------------------
// nrs_demap_ctrl -- receive-side NRS extraction sequencer for one NB-IoT
// subframe.
//
// Waits for each NRS-bearing OFDM symbol (l = 5, 6, 12, 13) from the post-FFT
// grid buffer. For each symbol it reads the NRS subcarriers from the grid and
// copies them into the channel-estimator buffer, then acknowledges the symbol.
//
// Build option:
//   NRS_PORT1_EN  defined   -> two antenna ports: four reads per symbol,
//                             est_wr_addr is 4 bits {port, slot, v_sel, re}
//                 undefined -> antenna port 0 only, est_wr_addr is 3 bits
//                             {slot, v_sel, re}
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   N_cell_ID, cfg_load  cell ID and its load strobe (honoured in IDLE only)
//   sf_start, nrs_sf     subframe start pulse, subframe-carries-NRS flag
//   abort                abandon the current subframe
//   sym_rdy, sym_idx     grid buffer holds symbol sym_idx (held until ack)
//   sym_ack              one-cycle pulse, symbol consumed
//   grid_rd_en/addr      grid read strobe and subcarrier index (0..11)
//   grid_rd_data         RE {I,Q}, valid the cycle after grid_rd_en
//   est_wr_en/addr/data  estimator buffer write, one cycle after each read
//   v_shift              registered N_cell_ID mod 6
//   busy, done, err      not-IDLE, final-write pulse, sf_start-while-busy
// ---------------------------------------------------------------------------

// NRS subcarrier index generator, receive side.
//   est_rd_addr_i = {v_sel, re}; m = re, v = v_sel ? 3 : 0
//   index_demap_o = (6m + v + v_shift) mod 12
module nrs_index_gen_rx (
    input  logic [2:0] v_shift_i,
    input  logic [1:0] est_rd_addr_i,
    output logic [3:0] index_demap_o
);

    logic [4:0] sum;

    always_comb begin
        sum = (est_rd_addr_i[0] ? 5'd6 : 5'd0)
            + (est_rd_addr_i[1] ? 5'd3 : 5'd0)
            + {2'b00, v_shift_i};
        // sum never exceeds 6 + 3 + 5 = 14, so one conditional wrap suffices
        if (sum >= 5'd12) begin
            index_demap_o = 4'(sum - 5'd12);
        end else begin
            index_demap_o = sum[3:0];
        end
    end

endmodule

module nrs_demap_ctrl #(
    parameter int unsigned DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8:0]      N_cell_ID,
    input  logic            cfg_load,
    input  logic            sf_start,
    input  logic            nrs_sf,
    input  logic            abort,
    input  logic            sym_rdy,
    input  logic [3:0]      sym_idx,
    output logic            sym_ack,
    output logic            grid_rd_en,
    output logic [3:0]      grid_rd_addr,
    input  logic [2*DW-1:0] grid_rd_data,
    output logic            est_wr_en,
`ifdef NRS_PORT1_EN
    output logic [3:0]      est_wr_addr,
`else
    output logic [2:0]      est_wr_addr,
`endif
    output logic [2*DW-1:0] est_wr_data,
    output logic [2:0]      v_shift,
    output logic            busy,
    output logic            done,
    output logic            err
);

`ifdef NRS_PORT1_EN
    localparam int unsigned WrAddrW = 4;
`else
    localparam int unsigned WrAddrW = 3;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWaitSym,
        StRd0,
        StRd1,
        StRd2,
        StRd3,
        StFin
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sym_cnt_q, sym_cnt_d;
    logic [2:0]           v_shift_q;
    logic                 wr_en_q;
    logic [WrAddrW-1:0]   wr_addr_q;
    logic [WrAddrW-1:0]   wr_addr_d;

    logic                 rd_en;
    logic                 rd_re;
    logic                 rd_port;
    logic                 v_sel_eff;
    logic [3:0]           l_exp;
    logic [3:0]           sc_index;

    // Expected symbol for the current schedule slot: 5, 6, 12, 13
    always_comb begin
        if (sym_cnt_q[1]) begin
            l_exp = 4'd12 + {3'b000, sym_cnt_q[0]};
        end else begin
            l_exp = 4'd5 + {3'b000, sym_cnt_q[0]};
        end
    end

    // Port 1 carries its NRS on the opposite frequency offset to port 0
    assign v_sel_eff = sym_cnt_q[0] ^ rd_port;

    nrs_index_gen_rx u_index_gen (
        .v_shift_i     (v_shift_q),
        .est_rd_addr_i ({v_sel_eff, rd_re}),
        .index_demap_o (sc_index)
    );

    // Next-state and per-state outputs
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        rd_en     = 1'b0;
        rd_re     = 1'b0;
        rd_port   = 1'b0;
        sym_ack   = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        err       = sf_start && (state_q != StIdle) && !abort;

        case (state_q)
            StIdle: begin
                if (sf_start && nrs_sf) begin
                    state_d   = StWaitSym;
                    sym_cnt_d = 2'd0;
                end
            end
            StWaitSym: begin
                // A symbol other than the expected one is left for upstream to flush
                if (sym_rdy && (sym_idx == l_exp)) begin
                    state_d = StRd0;
                end
            end
            StRd0: begin
                rd_en   = 1'b1;
                state_d = StRd1;
            end
            StRd1: begin
                rd_en = 1'b1;
                rd_re = 1'b1;
`ifdef NRS_PORT1_EN
                state_d = StRd2;
`else
                sym_ack = 1'b1;
                if (sym_cnt_q == 2'd3) begin
                    state_d = StFin;
                end else begin
                    sym_cnt_d = sym_cnt_q + 2'd1;
                    state_d   = StWaitSym;
                end
`endif
            end
`ifdef NRS_PORT1_EN
            StRd2: begin
                rd_en   = 1'b1;
                rd_port = 1'b1;
                state_d = StRd3;
            end
            StRd3: begin
                rd_en   = 1'b1;
                rd_port = 1'b1;
                rd_re   = 1'b1;
                sym_ack = 1'b1;
                if (sym_cnt_q == 2'd3) begin
                    state_d = StFin;
                end else begin
                    sym_cnt_d = sym_cnt_q + 2'd1;
                    state_d   = StWaitSym;
                end
            end
`endif
            StFin: begin
                // The last write of the subframe lands in this cycle
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including the ack and done pulses
        if (abort) begin
            state_d   = StIdle;
            sym_cnt_d = 2'd0;
            sym_ack   = 1'b0;
            done      = 1'b0;
        end
    end

    always_comb begin
`ifdef NRS_PORT1_EN
        wr_addr_d = {rd_port, sym_cnt_q[1], v_sel_eff, rd_re};
`else
        wr_addr_d = {sym_cnt_q[1], v_sel_eff, rd_re};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sym_cnt_q <= 2'd0;
            v_shift_q <= 3'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            if ((state_q == StIdle) && cfg_load) begin
                v_shift_q <= 3'(N_cell_ID % 9'd6);
            end
            // A read issued in the abort cycle never turns into a write
            wr_en_q   <= rd_en && !abort;
            wr_addr_q <= rd_en ? wr_addr_d : '0;
        end
    end

    assign grid_rd_en   = rd_en;
    assign grid_rd_addr = rd_en ? sc_index : 4'd0;
    assign est_wr_en    = wr_en_q;
    assign est_wr_addr  = wr_addr_q;
    // The grid buffer registers its read data, so it already arrives in the
    // same cycle as the delayed write strobe; gate it so the bus idles at 0.
    assign est_wr_data  = wr_en_q ? grid_rd_data : '0;
    assign v_shift      = v_shift_q;

endmodule

// File: tb/tb_nrs_demap_ctrl.sv
// Scoreboard bench for nrs_demap_ctrl: stimulus pushes expected reads and
// writes into queues, a monitor pops and compares them as the DUT presents
// grid reads and estimator writes.
module tb_nrs_demap_ctrl;

    localparam int DW = 16;
`ifdef NRS_PORT1_EN
    localparam int NP = 2;
    localparam int AW = 4;
`else
    localparam int NP = 1;
    localparam int AW = 3;
`endif

    logic            clk;
    logic            rst_n;
    logic [8:0]      N_cell_ID;
    logic            cfg_load;
    logic            sf_start;
    logic            nrs_sf;
    logic            abort;
    logic            sym_rdy;
    logic [3:0]      sym_idx;
    logic            sym_ack;
    logic            grid_rd_en;
    logic [3:0]      grid_rd_addr;
    logic [2*DW-1:0] grid_rd_data;
    logic            est_wr_en;
    logic [AW-1:0]   est_wr_addr;
    logic [2*DW-1:0] est_wr_data;
    logic [2:0]      v_shift;
    logic            busy;
    logic            done;
    logic            err;

    nrs_demap_ctrl #(.DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .N_cell_ID    (N_cell_ID),
        .cfg_load     (cfg_load),
        .sf_start     (sf_start),
        .nrs_sf       (nrs_sf),
        .abort        (abort),
        .sym_rdy      (sym_rdy),
        .sym_idx      (sym_idx),
        .sym_ack      (sym_ack),
        .grid_rd_en   (grid_rd_en),
        .grid_rd_addr (grid_rd_addr),
        .grid_rd_data (grid_rd_data),
        .est_wr_en    (est_wr_en),
        .est_wr_addr  (est_wr_addr),
        .est_wr_data  (est_wr_data),
        .v_shift      (v_shift),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*DW-1:0] data;
        bit              last;
    } wr_t;

    logic [2*DW-1:0] mem [16][16];
    int              rd_q[$];
    wr_t             wr_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              done_cnt = 0;
    int              exp_vs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grid buffer model: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        if (grid_rd_en === 1'b1) grid_rd_data <= mem[sym_idx][grid_rd_addr];
        else                     grid_rd_data <= '0;
    end

    function automatic int l_of(input int k);
        return (k < 2) ? 5 + k : 10 + k;
    endfunction

    // Reference: NRS subcarriers of schedule slot k, in read order
    task automatic push_sym(input int k, input int nreads, input int nwrites);
        int  n;
        int  v;
        int  idx;
        wr_t w;
        n = 0;
        for (int p = 0; p < NP; p++) begin
            for (int re = 0; re < 2; re++) begin
                v   = (((k % 2) == 1) != (p == 1)) ? 3 : 0;
                idx = (6 * re + v + exp_vs) % 12;
                if (n < nreads) rd_q.push_back(idx);
                if (n < nwrites) begin
                    w.addr = AW'(p * 8 + (k / 2) * 4 + ((v == 3) ? 2 : 0) + re);
                    w.data = mem[l_of(k)][idx];
                    w.last = (k == 3) && (n == 2 * NP - 1);
                    wr_q.push_back(w);
                end
                n++;
            end
        end
    endtask

    // Monitor: sample just before each rising edge
    always @(negedge clk) begin
        int  ra;
        wr_t w;
        #4;
        if (grid_rd_en === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_grid_rd", 64'(grid_rd_en), 64'(0));
            end else begin
                ra = rd_q.pop_front();
                chk("grid_rd_addr", 64'(grid_rd_addr), 64'(ra));
            end
        end
        if (est_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_est_wr", 64'(est_wr_en), 64'(0));
            end else begin
                w = wr_q.pop_front();
                chk("est_wr_addr", 64'(est_wr_addr), 64'(w.addr));
                chk("est_wr_data", 64'(est_wr_data), 64'(w.data));
                chk("done_with_write", 64'(done), 64'(w.last));
            end
        end else if (done === 1'b1) begin
            chk("done_without_write", 64'(done), 64'(0));
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic present_wrong(input int k, input int l_force);
        int l;
        l = l_force;
        if (l < 0) begin
            l = $urandom_range(0, 13);
            if (l == l_of(k)) l = (l + 1) % 14;
        end
        @(negedge clk);
        sym_rdy = 1'b1;
        sym_idx = 4'(l);
        repeat (3) begin
            @(negedge clk);
            #4;
            chk("wrong_sym_no_ack", 64'(sym_ack), 64'(0));
            chk("wrong_sym_no_read", 64'(grid_rd_en), 64'(0));
        end
        @(negedge clk);
        sym_rdy = 1'b0;
    endtask

    // mode: 0 plain, 1 sf_start+cfg_load in RD0, 2 abort in RD0, 3 reset in RD1
    task automatic present_symbol(input int k, input int mode);
        bit seen;
        case (mode)
            2:       push_sym(k, 1, 0);
            3:       push_sym(k, 2, 1);
            default: push_sym(k, 2 * NP, 2 * NP);
        endcase
        @(negedge clk);
        sym_rdy = 1'b1;
        sym_idx = 4'(l_of(k));
        @(negedge clk);
        if (mode == 1) begin
            sf_start  = 1'b1;
            nrs_sf    = 1'b1;
            cfg_load  = 1'b1;
            N_cell_ID = 9'd7;
        end
        if (mode == 2) begin
            abort    = 1'b1;
            sf_start = 1'b1;
            nrs_sf   = 1'b1;
        end
        #4;
        chk("rd0_after_accept", 64'(grid_rd_en), 64'(1));
        if (mode == 1) chk("err_sf_start_busy", 64'(err), 64'(1));
        if (mode == 2) chk("err_masked_by_abort", 64'(err), 64'(0));
        if (mode == 2) begin
            @(negedge clk);
            abort    = 1'b0;
            sf_start = 1'b0;
            sym_rdy  = 1'b0;
            #4;
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_no_write", 64'(est_wr_en), 64'(0));
            chk("abort_no_read", 64'(grid_rd_en), 64'(0));
            return;
        end
        if (mode == 3) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_sym_ack", 64'(sym_ack), 64'(0));
            chk("rst_grid_rd_en", 64'(grid_rd_en), 64'(0));
            chk("rst_grid_rd_addr", 64'(grid_rd_addr), 64'(0));
            chk("rst_est_wr_en", 64'(est_wr_en), 64'(0));
            chk("rst_est_wr_addr", 64'(est_wr_addr), 64'(0));
            chk("rst_est_wr_data", 64'(est_wr_data), 64'(0));
            chk("rst_v_shift", 64'(v_shift), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
            exp_vs = 0;
            @(negedge clk);
            rst_n   = 1'b1;
            sym_rdy = 1'b0;
            return;
        end
        if (mode == 1) begin
            @(negedge clk);
            sf_start = 1'b0;
            cfg_load = 1'b0;
            #4;
            chk("err_one_cycle", 64'(err), 64'(0));
        end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (sym_ack === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                #4;
            end
        end
        chk("sym_ack_seen", 64'(seen), 64'(1));
        @(negedge clk);
        sym_rdy = 1'b0;
    endtask

    // junk: 0 none, 1 random wrong symbols, 2 symbol 4 before symbol 5
    task automatic run_subframe(input int id, input int junk, input int msym, input int mode);
        int d0;
        bit stopped;
        bit idle;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) mem[i][j] = $urandom;
        @(negedge clk);
        cfg_load  = 1'b1;
        N_cell_ID = 9'(id);
        exp_vs    = id % 6;
        @(negedge clk);
        cfg_load = 1'b0;
        #4;
        chk("v_shift_load", 64'(v_shift), 64'(exp_vs));
        d0 = done_cnt;
        @(negedge clk);
        sf_start = 1'b1;
        nrs_sf   = 1'b1;
        @(negedge clk);
        sf_start = 1'b0;
        #4;
        chk("busy_after_sf_start", 64'(busy), 64'(1));
        stopped = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (junk == 2 && k == 0) present_wrong(0, 4);
            if (junk == 1 && ($urandom % 2) == 1) present_wrong(k, -1);
            present_symbol(k, (k == msym) ? mode : 0);
            if (k == msym && mode >= 2) begin
                stopped = 1'b1;
                break;
            end
        end
        idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            #4;
            if (busy === 1'b0) idle = 1'b1;
        end
        chk("returns_idle", 64'(idle), 64'(1));
        repeat (3) @(negedge clk);
        #4;
        chk("reads_drained", 64'(rd_q.size()), 64'(0));
        chk("writes_drained", 64'(wr_q.size()), 64'(0));
        chk("done_count", 64'(done_cnt - d0), 64'(stopped ? 0 : 1));
        chk("v_shift_kept", 64'(v_shift), 64'(exp_vs));
        rd_q.delete();
        wr_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        N_cell_ID = '0;
        cfg_load  = 1'b0;
        sf_start  = 1'b0;
        nrs_sf    = 1'b0;
        abort     = 1'b0;
        sym_rdy   = 1'b0;
        sym_idx   = '0;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_v_shift", 64'(v_shift), 64'(0));
        chk("reset_est_wr_en", 64'(est_wr_en), 64'(0));
        chk("reset_grid_rd_en", 64'(grid_rd_en), 64'(0));
        chk("reset_sym_ack", 64'(sym_ack), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_subframe(0, 0, -1, 0);                              // cell 0
        run_subframe(503, 0, 0, 1);                             // v_shift 5, err, cfg ignored
        run_subframe(int'($urandom_range(0, 503)), 2, -1, 0);   // wrong symbol first
        run_subframe(int'($urandom_range(0, 503)), 0, 2, 2);    // abort at symbol 12
        run_subframe(int'($urandom_range(0, 503)), 1, -1, 0);   // restart after abort
        run_subframe(int'($urandom_range(0, 503)), 0, 1, 3);    // reset in symbol 6

        // Subframe without NRS stays idle
        @(negedge clk);
        sf_start = 1'b1;
        nrs_sf   = 1'b0;
        @(negedge clk);
        sf_start = 1'b0;
        repeat (3) begin
            #4;
            chk("no_nrs_idle", 64'(busy), 64'(0));
            chk("no_nrs_no_read", 64'(grid_rd_en), 64'(0));
            @(negedge clk);
        end

        for (int n = 0; n < 6; n++) run_subframe(int'($urandom_range(0, 503)), 1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
